// File: rtl/game_link_tx.sv
// Game-link UART transmitter: turns game state changes and score requests into 8N1 event frames.
// Optional build macro LINK_CRC_EN appends an XOR checksum byte to every frame.
module game_link_tx #(
  parameter int          CLKS_PER_BIT = 6771,
  parameter logic [3:0]  HDR          = 4'hA
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [1:0] state_in,
  input  logic [7:0] score_in,
  input  logic       tx_req,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef LINK_CRC_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          fsm;
  logic [1:0]      state_prev;
  logic            pend_st;
  logic            pend_sc;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [1:0]      byte_idx;
  logic [7:0]      shreg;
  logic [7:0]      byte1_q;
`ifdef LINK_CRC_EN
  logic [7:0]      byte2_q;
`endif

  logic            bit_end;
  logic            grant_st;
  logic            grant_sc;
  logic [7:0]      byte0_w;
  logic [7:0]      next_byte;

  // Requests are fire-and-forget: a state change or a tx_req pulse only
  // raises a one-deep pending flag; there is no back-pressure to the sender.
  always_comb begin
    bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    grant_st  = (fsm == S_IDLE) && pend_st;
    grant_sc  = (fsm == S_IDLE) && !pend_st && pend_sc;
    byte0_w   = {HDR, (pend_st ? 2'b01 : 2'b10), state_in};
`ifdef LINK_CRC_EN
    next_byte = (byte_idx == 2'd0) ? byte1_q : byte2_q;
`else
    next_byte = byte1_q;
`endif
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= S_IDLE;
      state_prev <= 2'b00;
      pend_st    <= 1'b0;
      pend_sc    <= 1'b0;
      clk_cnt    <= '0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
      shreg      <= 8'h00;
      byte1_q    <= 8'h00;
`ifdef LINK_CRC_EN
      byte2_q    <= 8'h00;
`endif
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      state_prev <= state_in;
      // A new event on the grant cycle wins, so the flag stays set.
      pend_st    <= (state_in != state_prev) | (pend_st & ~grant_st);
      pend_sc    <= tx_req | (pend_sc & ~grant_sc);

      case (fsm)
        S_IDLE: begin
          clk_cnt <= '0;
          if (pend_st || pend_sc) begin
            shreg    <= byte0_w;
            byte1_q  <= score_in;
`ifdef LINK_CRC_EN
            byte2_q  <= byte0_w ^ score_in;
`endif
            byte_idx <= 2'd0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            fsm      <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            tx      <= shreg[0];
            fsm     <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx  <= 1'b1;
              fsm <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (byte_idx == 2'(NBYTES - 1)) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              fsm        <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              shreg    <= next_byte;
              tx       <= 1'b0;
              fsm      <= S_START;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_link_tx.sv
// Directed bench for game_link_tx: decodes the serial line at mid-bit and
// compares bytes and frame timing against an expected-byte queue.
module tb_game_link_tx;

  localparam int CPB = 4;
`ifdef LINK_CRC_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int FRAME_CYC = NB * 10 * CPB;

  logic       pclk;
  logic       rst_n;
  logic [1:0] state_in;
  logic [7:0] score_in;
  logic       tx_req;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_start = 0;
  int last_end = 0;
  logic [7:0] exp_q[$];

  game_link_tx #(.CLKS_PER_BIT(CPB), .HDR(4'hA)) dut (
    .pclk(pclk), .rst_n(rst_n), .state_in(state_in), .score_in(score_in),
    .tx_req(tx_req), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  // clock / reset block
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
`ifdef LINK_CRC_EN
    exp_q.push_back(b0 ^ b1);
`endif
  endtask

  task automatic idle_check(input int n);
    int bad_tx = 0;
    int bad_busy = 0;
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (frame_done !== 1'b0) pulses++;
    end
    check("idle_tx_low_cycles", bad_tx, 0);
    check("idle_busy_cycles", bad_busy, 0);
    check("idle_frame_done_pulses", pulses, 0);
  endtask

  // Receives one whole frame starting from the next falling edge of tx.
  task automatic rx_frame(input int nbytes);
    bit found = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int j;
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge pclk);
      if (tx === 1'b0) found = 1;
    end
    check("frame_start_seen", 32'(found), 1);
    if (!found) return;
    last_start = cyc;
    for (int o = 0; o < nbytes * 10 * CPB; o++) begin
      if (o > 0) @(negedge pclk);
      if (busy === 1'b1) busy_cnt++;
      if (frame_done === 1'b1) done_cnt++;
      if (o % CPB == CPB / 2) begin
        j = (o / CPB) % 10;
        if (j == 0) check("start_bit", 32'(tx), 0);
        else if (j < 9) b[j-1] = tx;
        else begin
          check("stop_bit", 32'(tx), 1);
          if (exp_q.size() == 0) check("unexpected_byte", 32'(b), 32'hFFFF);
          else check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
    end
    @(negedge pclk);
    last_end = cyc;
    check("frame_done_at_end", 32'(frame_done), 1);
    check("busy_low_at_end", 32'(busy), 0);
    check("busy_high_cycles", busy_cnt, nbytes * 10 * CPB);
    check("early_frame_done", done_cnt, 0);
    check("frame_length", last_end - last_start, nbytes * 10 * CPB);
  endtask

  // driver / directed sequence
  initial begin
    int c0;
    int end1;
    rst_n = 1'b0; state_in = 2'b00; score_in = 8'h00; tx_req = 1'b0;

    // 1: reset state and idle line
    repeat (3) @(negedge pclk);
    check("reset_tx", 32'(tx), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    rst_n = 1'b1;
    idle_check(200);

    // 2: state change 00->01, tx falls two cycles after the change
    score_in = 8'h5A;
    state_in = 2'b01;
    c0 = cyc;
    push_frame(8'hA5, 8'h5A);
    rx_frame(NB);
    check("start_latency", last_start - c0, 2);

    // 3: state 01->10 frame, then a score-report frame
    @(negedge pclk);
    score_in = 8'h3C;
    state_in = 2'b10;
    push_frame(8'hA6, 8'h3C);
    rx_frame(NB);
    @(negedge pclk);
    tx_req = 1'b1;
    push_frame(8'hAA, 8'h3C);
    @(negedge pclk);
    tx_req = 1'b0;
    rx_frame(NB);

    // 4: state change and tx_req in the same cycle, back to back
    state_in = 2'b01;
    push_frame(8'hA5, 8'h3C);
    rx_frame(NB);
    @(negedge pclk);
    state_in = 2'b10;
    tx_req = 1'b1;
    push_frame(8'hA6, 8'h3C);
    push_frame(8'hAA, 8'h3C);
    @(negedge pclk);
    tx_req = 1'b0;
    rx_frame(NB);
    end1 = last_end;
    rx_frame(NB);
    check("back_to_back_gap", last_start - end1, 1);

    // 5: reset in the middle of byte1 bit0 (a 0 bit of 8'h3C)
    @(negedge pclk);
    state_in = 2'b11;
    begin
      bit found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
        @(negedge pclk);
        if (tx === 1'b0) found = 1;
      end
      check("abort_frame_start", 32'(found), 1);
    end
    repeat (11 * CPB + 1) @(negedge pclk);
    check("abort_pre_tx", 32'(tx), 0);
    check("abort_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_tx_high", 32'(tx), 1);
    check("abort_busy_low", 32'(busy), 0);
    state_in = 2'b00;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    idle_check(200);

    // 6: zero score, state 00->01 (three bytes with the checksum build)
    score_in = 8'h00;
    state_in = 2'b01;
    push_frame(8'hA5, 8'h00);
    rx_frame(NB);
    check("frame_cycles_total", last_end - last_start, FRAME_CYC);
    idle_check(20);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
